// File: rtl/ixu_div_multi.sv
// Iterative integer divider for DIV/DIVU/REM/REMU and their 32-bit *W forms.
// Restoring division resolves BPC quotient bits per cycle; divide-by-zero and signed overflow finish in one cycle.
module ixu_div_multi #(
    parameter int XLEN  = 32,
    parameter int BPC   = 1,
    parameter int TAG_W = 6
) (
    input  logic             core_clock_i,
    input  logic             core_reset_ni,
    input  logic             core_flush_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             valid_o,
    input  logic             res_ready_i,
    output logic [XLEN-1:0]  res_o,
    output logic             dbz_o,
    output logic             overflow_o
);

    localparam int ACC_W = XLEN + BPC;
    localparam int CNT_W = $clog2(XLEN / BPC + 1);
    localparam logic [CNT_W-1:0] STEPS_FULL = CNT_W'(XLEN / BPC);
    localparam logic [CNT_W-1:0] STEPS_WORD = CNT_W'(32 / BPC);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic             accept;
    logic             is_signed, is_rem, word_eff;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_val;
    logic             a_neg, b_neg, dbz, ovf;

    logic [ACC_W-1:0] acc, acc_step, dvs_ext;
    logic [XLEN-1:0]  quo, quo_step, dvs;
    logic [CNT_W-1:0] cnt;
    logic             rem_q, word_q, neg_quo_q, neg_rem_q;
    logic [XLEN-1:0]  res_q, res_div, rem_val;
    logic [TAG_W-1:0] tag_q;
    logic             dbz_q, ovf_q;

    // Sign-extend the low word to full width for *W results.
    function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic w);
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    assign is_signed = ~op_i[0];
    assign is_rem    = op_i[1];
    assign word_eff  = (XLEN == 64) && word_i;
    assign accept    = start_i && ready_o && !core_flush_i;

    always_comb begin
        a_ext   = a_i;
        b_ext   = b_i;
        min_val = {1'b1, {(XLEN-1){1'b0}}};
        if (word_eff) begin
            a_ext   = is_signed ? XLEN'($signed(a_i[31:0])) : XLEN'(a_i[31:0]);
            b_ext   = is_signed ? XLEN'($signed(b_i[31:0])) : XLEN'(b_i[31:0]);
            min_val = XLEN'($signed(32'h8000_0000));
        end
        a_neg = is_signed && a_ext[XLEN-1];
        b_neg = is_signed && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        dbz   = (b_ext == '0);
        ovf   = is_signed && (a_ext == min_val) && (b_ext == '1);
    end

    // One BUSY cycle worth of restoring steps; the remainder never exceeds the divisor, so ACC_W cannot overflow.
    assign dvs_ext = {{BPC{1'b0}}, dvs};

    always_comb begin
        acc_step = acc;
        quo_step = quo;
        for (int i = 0; i < BPC; i++) begin
            acc_step = {acc_step[ACC_W-2:0], quo_step[XLEN-1]};
            quo_step = {quo_step[XLEN-2:0], 1'b0};
            if (acc_step >= dvs_ext) begin
                acc_step    = acc_step - dvs_ext;
                quo_step[0] = 1'b1;
            end
        end
    end

    assign rem_val = acc_step[XLEN-1:0];

    always_comb begin
        res_div = '0;
        if (rem_q) begin
            res_div = neg_rem_q ? -rem_val : rem_val;
        end else begin
            res_div = neg_quo_q ? -quo_step : quo_step;
        end
        res_div = fix_word(res_div, word_q);
    end

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = (state == IDLE);
        valid_o    = (state == DONE);
        case (state)
            IDLE:    if (start_i) state_next = (dbz || ovf) ? DONE : BUSY;
            BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    if (res_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (core_flush_i) begin
            state_next = IDLE;
        end
    end

    // For *W ops the dividend is preloaded into the top word so only 32 bits are shifted out.
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            acc       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            rem_q     <= 1'b0;
            word_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            res_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (core_flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            acc       <= '0;
            quo       <= word_eff ? (a_mag << (XLEN - 32)) : a_mag;
            dvs       <= b_mag;
            cnt       <= (dbz || ovf) ? '0 : (word_eff ? STEPS_WORD : STEPS_FULL);
            rem_q     <= is_rem;
            word_q    <= word_eff;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            tag_q     <= tag_i;
            dbz_q     <= dbz;
            ovf_q     <= ovf && !dbz;
            if (dbz) begin
                res_q <= fix_word(is_rem ? a_ext : '1, word_eff);
            end else if (ovf) begin
                res_q <= fix_word(is_rem ? '0 : a_ext, word_eff);
            end else begin
                res_q <= '0;
            end
        end else if (state == BUSY) begin
            acc <= acc_step;
            quo <= quo_step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                res_q <= res_div;
            end
        end
    end

    assign res_o      = res_q;
    assign tag_o      = tag_q;
    assign dbz_o      = dbz_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/ixu_div_multi.md
IXU_DIV_MULTI -- requirements
Module: ixu_div_multi

Interface
- REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal values: 32, 64).
- REQ-002 SHALL have parameter BPC, default 1, quotient bits resolved per cycle (legal values: 1, 2, 4; must divide 32).
- REQ-003 SHALL have parameter TAG_W, default 6, width of the opaque tag carried with each operation.
- REQ-004 SHALL have port core_clock_i, input, 1, the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port core_reset_ni, input, 1, reset: asynchronous, active-low.
- REQ-006 SHALL have port core_flush_i, input, 1, synchronous pipeline flush, active-high.
- REQ-007 SHALL have port start_i, input, 1, operation request valid.
- REQ-008 SHALL have port ready_o, output, 1, block can accept a request.
- REQ-009 SHALL have port op_i, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- REQ-010 SHALL have port word_i, input, 1, 32-bit *W operation; ignored when XLEN=32.
- REQ-011 SHALL have port a_i and b_i, input, XLEN each, dividend and divisor.
- REQ-012 SHALL have port tag_i, input, TAG_W, tag; tag_o, output, TAG_W, the returned tag.
- REQ-013 SHALL have port valid_o, output, 1, result valid; res_ready_i, input, 1, consumer accepts the result.
- REQ-014 SHALL have port res_o, output, XLEN, result; dbz_o and overflow_o, output, 1 each, status flags qualified by valid_o.

Function
- REQ-015 SHALL implement the states IDLE, BUSY and DONE; a request is accepted when start_i && ready_o; ready_o=1 only in IDLE.
- REQ-016 SHALL latch op, word, tag and the operand magnitudes on accept; operand inputs are don't-care after the accept cycle.
- REQ-017 SHALL use operating width W=32 when word_i=1 and XLEN=64, otherwise W=XLEN; *W operands are taken as a_i[31:0] and b_i[31:0], sign-extended or zero-extended per op.
- REQ-018 SHALL, for signed ops, divide on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- REQ-019 SHALL, on divisor==0 (within W), go IDLE->DONE in 1 cycle with dbz_o=1 and res = all-ones (DIV/DIVU) or the dividend (REM/REMU).
- REQ-020 SHALL, on signed dividend = -2^(W-1) and divisor = -1, go IDLE->DONE in 1 cycle with overflow_o=1 and res = dividend (DIV) or 0 (REM).
- REQ-021 SHALL otherwise perform restoring division, resolving BPC quotient bits per BUSY cycle, for exactly W/BPC BUSY cycles, then enter DONE.
- REQ-022 SHALL have a normal latency of W/BPC+1 cycles: valid_o first high exactly W/BPC+1 cycles after the accept edge.
- REQ-023 SHALL sign-extend the 32-bit result to XLEN for *W ops, including dbz and overflow results.
- REQ-024 SHALL hold res_o, tag_o, dbz_o, overflow_o and valid_o stable in DONE until res_ready_i=1, then return to IDLE on that edge.
- REQ-025 SHALL not accept a new request in the same cycle as the DONE->IDLE handoff (ready_o=0 in DONE).
- REQ-026 SHALL, on core_flush_i=1 in any state, go to IDLE on the next edge with valid_o=0 and ready_o=1; flush takes priority over start_i and res_ready_i.
- REQ-027 SHALL keep accumulator width W+BPC to avoid overflow in multi-bit steps.

Reset
- REQ-028 SHALL, while core_reset_ni=0, asynchronously force state IDLE, ready_o=1, valid_o=0, dbz_o=0, overflow_o=0, res_o=0, tag_o=0, and the iteration counter to 0.
- REQ-029 SHALL, when reset deasserts mid-operation, discard the in-flight operation with no valid_o pulse.

Verification
- REQ-030 SHALL cover XLEN=32, BPC=1, DIV a=-7, b=2, tag=5: valid_o 33 cycles after accept, res=-3 (0xFFFFFFFD), tag_o=5.
- REQ-031 SHALL cover XLEN=32, BPC=4, REM a=-7, b=2: valid_o 9 cycles after accept, res=0xFFFFFFFF (-1).
- REQ-032 SHALL cover DIVU with b=0, a=0x1234: valid_o 1 cycle after accept, dbz_o=1, res=0xFFFFFFFF; REMU with b=0 returns res=0x1234.
- REQ-033 SHALL cover XLEN=64, word_i=1, DIV a=0x80000000, b=0xFFFFFFFF: overflow_o=1, res=0xFFFFFFFF80000000.
- REQ-034 SHALL cover a result held with res_ready_i=0 for 10 cycles: outputs stable and ready_o=0; IDLE on the edge where res_ready_i=1.
- REQ-035 SHALL cover core_flush_i during BUSY iteration 3 and core_reset_ni low during BUSY: both return to IDLE, no valid_o, and the next request yields the correct result.
